// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the cache refill read arbiter.
// Imported by the arbiter top and its round-robin helper.
package cache_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  localparam int ID_ICACHE = 0;
  localparam int ID_DCACHE = 1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/cache_axi_rd_arbiter_arb_rr2.sv
// Two-way round-robin arbiter; bit 0 = icache, bit 1 = dcache.
// last_grant resets to icache so dcache wins the first tie.
module arb_rr2
  import cache_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
      (req == 2'b10): gnt = 2'b10;
      (req == 2'b01): gnt = 2'b01;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b0;
    end else if (update) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Merges icache and dcache refill reads onto one AXI4 read master.
// One burst outstanding; grant held from AR issue until rlast.
module cache_axi_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter int ID_W       = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_arvalid,
  input  logic [31:0]     i_araddr,
  output logic            i_arready,
  output logic            i_rvalid,
  output logic            i_rlast,
  output logic [31:0]     i_rdata,
  input  logic            i_rready,
  input  logic            d_arvalid,
  input  logic [31:0]     d_araddr,
  input  logic            d_uncached,
  output logic            d_arready,
  output logic            d_rvalid,
  output logic            d_rlast,
  output logic [31:0]     d_rdata,
  input  logic            d_rready,
  output logic [ID_W-1:0] m_arid,
  output logic [31:0]     m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [ID_W-1:0] m_rid,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic            rd_err
);

  state_e     state;
  logic       owner_d;
  logic [7:0] beat_cnt;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       take;
  logic       ar_hs;
  logic       r_hs;
  logic       own_rready;
  logic       in_r;

  assign req  = {d_arvalid, i_arvalid};
  assign take = (state == IDLE) && (|req);

  arb_rr2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .update (take),
    .gnt    (gnt)
  );

  assign in_r       = (state == R);
  assign own_rready = owner_d ? d_rready : i_rready;
  assign ar_hs      = (state == AR) && m_arready;
  assign r_hs       = in_r && m_rvalid && own_rready;

  assign m_arvalid = (state == AR);
  assign i_arready = ar_hs && !owner_d;
  assign d_arready = ar_hs && owner_d;

  assign m_rready = in_r && own_rready;
  assign i_rvalid = in_r && !owner_d && m_rvalid;
  assign i_rlast  = in_r && !owner_d && m_rlast;
  assign d_rvalid = in_r && owner_d && m_rvalid;
  assign d_rlast  = in_r && owner_d && m_rlast;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      beat_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            owner_d   <= gnt[1];
            m_araddr  <= gnt[0] ? i_araddr : d_araddr;
            m_arid    <= gnt[0] ? ID_W'(ID_ICACHE)
                                : ID_W'(ID_DCACHE);
            m_arlen   <= (gnt[1] && d_uncached)
                         ? 8'd0 : 8'(LINE_BEATS - 1);
            m_arsize  <= AXI_SIZE_4B;
            m_arburst <= AXI_BURST_INCR;
            state     <= AR;
          end
        end
        AR: begin
          if (m_arready) begin
            beat_cnt <= '0;
            state    <= R;
          end
        end
        R: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_rlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // beat_cnt is the index of the current beat; rlast belongs at arlen
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_err <= 1'b0;
    end else if (r_hs) begin
      if (m_rresp != AXI_RESP_OKAY) rd_err <= 1'b1;
      if (m_rlast && beat_cnt != m_arlen) rd_err <= 1'b1;
      if (!m_rlast && beat_cnt >= m_arlen) rd_err <= 1'b1;
    end
  end

  rid_match: assert property (
    @(posedge clk) disable iff (!rstn)
    r_hs |-> (m_rid == m_arid)
  );

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter with a transaction-level model
// and a per-cycle output compare on the falling edge.
module tb_cache_axi_rd_arbiter;

  localparam int LINE_BEATS = 4;
  localparam int ID_W       = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            i_arvalid = 1'b0;
  logic [31:0]     i_araddr = '0;
  logic            i_arready;
  logic            i_rvalid;
  logic            i_rlast;
  logic [31:0]     i_rdata;
  logic            i_rready = 1'b1;
  logic            d_arvalid = 1'b0;
  logic [31:0]     d_araddr = '0;
  logic            d_uncached = 1'b0;
  logic            d_arready;
  logic            d_rvalid;
  logic            d_rlast;
  logic [31:0]     d_rdata;
  logic            d_rready = 1'b1;
  logic [ID_W-1:0] m_arid;
  logic [31:0]     m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [ID_W-1:0] m_rid = '0;
  logic [31:0]     m_rdata = '0;
  logic [1:0]      m_rresp = '0;
  logic            m_rlast = 1'b0;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic            rd_err;

  always #5 clk = ~clk;

  cache_axi_rd_arbiter #(
    .LINE_BEATS (LINE_BEATS),
    .ID_W       (ID_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_arvalid  (i_arvalid),
    .i_araddr   (i_araddr),
    .i_arready  (i_arready),
    .i_rvalid   (i_rvalid),
    .i_rlast    (i_rlast),
    .i_rdata    (i_rdata),
    .i_rready   (i_rready),
    .d_arvalid  (d_arvalid),
    .d_araddr   (d_araddr),
    .d_uncached (d_uncached),
    .d_arready  (d_arready),
    .d_rvalid   (d_rvalid),
    .d_rlast    (d_rlast),
    .d_rdata    (d_rdata),
    .d_rready   (d_rready),
    .m_arid     (m_arid),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_arsize   (m_arsize),
    .m_arburst  (m_arburst),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rid      (m_rid),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rlast    (m_rlast),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .rd_err     (rd_err)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 waiting for a request, 1 address offered,
  // 2 data beats flowing. Counts beats delivered, not beat index.
  int   ph = 0;
  bit   own_d = 1'b0;
  bit   last_d = 1'b0;
  bit   err = 1'b0;
  int   nb = 0;
  int   len = 0;
  logic [31:0] mdl_addr = '0;
  bit   pick_d;

  assign pick_d = (i_arvalid && d_arvalid) ? !last_d : d_arvalid;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph <= 0; own_d <= 1'b0; last_d <= 1'b0;
      err <= 1'b0; nb <= 0; len <= 0; mdl_addr <= '0;
    end else if (ph == 0) begin
      if (i_arvalid || d_arvalid) begin
        own_d    <= pick_d;
        last_d   <= pick_d;
        mdl_addr <= pick_d ? d_araddr : i_araddr;
        len      <= (pick_d && d_uncached) ? 0 : LINE_BEATS - 1;
        ph       <= 1;
      end
    end else if (ph == 1) begin
      if (m_arready) begin
        ph <= 2;
        nb <= 0;
      end
    end else if (m_rvalid && (own_d ? d_rready : i_rready)) begin
      nb <= nb + 1;
      if (m_rresp != 2'b00) err <= 1'b1;
      if (m_rlast) begin
        if (nb + 1 != len + 1) err <= 1'b1;
        ph <= 0;
      end else if (nb + 1 > len) begin
        err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_arvalid", m_arvalid, ph == 1);
      check("i_arready", i_arready, ph == 1 && m_arready && !own_d);
      check("d_arready", d_arready, ph == 1 && m_arready && own_d);
      check("i_rvalid", i_rvalid, ph == 2 && !own_d && m_rvalid);
      check("i_rlast", i_rlast, ph == 2 && !own_d && m_rlast);
      check("d_rvalid", d_rvalid, ph == 2 && own_d && m_rvalid);
      check("d_rlast", d_rlast, ph == 2 && own_d && m_rlast);
      check("m_rready", m_rready,
            ph == 2 && (own_d ? d_rready : i_rready));
      check("i_rdata", i_rdata, m_rdata);
      check("d_rdata", d_rdata, m_rdata);
      check("rd_err", rd_err, err);
      if (ph == 1) begin
        check("m_araddr", m_araddr, mdl_addr);
        check("m_arid", 32'(m_arid), own_d ? 32'd1 : 32'd0);
        check("m_arlen", 32'(m_arlen), len);
        check("m_arsize", 32'(m_arsize), 32'd2);
        check("m_arburst", 32'(m_arburst), 32'd1);
      end
      if (!rstn) begin
        check("rst_araddr", m_araddr, 32'd0);
        check("rst_arlen", 32'(m_arlen), 32'd0);
        check("rst_arsize", 32'(m_arsize), 32'd0);
      end
      if (i_rvalid && i_rready) iq.push_back(i_rdata);
      if (d_rvalid && d_rready) dq.push_back(d_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input bit d, input logic [31:0] a,
                       input logic [7:0] l, input int dly);
    int n;
    n = 0;
    while (!m_arvalid && n < 20) begin
      tick();
      n++;
    end
    if (!m_arvalid) begin
      check("ar_timeout", 32'd0, 32'd1);
      return;
    end
    check("lit_arid", 32'(m_arid), 32'(d));
    check("lit_araddr", m_araddr, a);
    check("lit_arlen", 32'(m_arlen), 32'(l));
    repeat (dly) tick();
    m_arready = 1'b1;
    #1;
    check("lit_own_arready", d ? d_arready : i_arready, 32'd1);
    check("lit_oth_arready", d ? i_arready : d_arready, 32'd0);
    tick();
    m_arready = 1'b0;
    if (d) d_arvalid = 1'b0;
    else i_arvalid = 1'b0;
  endtask

  task automatic do_r(input int nbeats, input int last_at,
                      input int bad, input bit toggle,
                      input logic [ID_W-1:0] id,
                      input logic [31:0] base);
    int n;
    bit hs;
    for (int k = 0; k < nbeats; k++) begin
      n  = 0;
      hs = 1'b0;
      m_rvalid = 1'b1;
      m_rid    = id;
      m_rdata  = base + 32'(k);
      m_rlast  = (k == last_at);
      m_rresp  = (k == bad) ? 2'd2 : 2'd0;
      while (!hs && n < 20) begin
        if (toggle) i_rready = ~i_rready;
        @(negedge clk);
        hs = m_rready;
        tick();
        n++;
      end
      if (!hs) check("r_timeout", 32'd0, 32'd1);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'd0;
    i_rready = 1'b1;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_arvalid", m_arvalid, 32'd0);
    check("rst_rd_err", rd_err, 32'd0);
    rstn = 1'b1;
    tick();

    // icache alone, arready two cycles late
    i_araddr = 32'h1C00_0040;
    i_arvalid = 1'b1;
    do_ar(1'b0, 32'h1C00_0040, 8'd3, 2);
    do_r(4, 3, -1, 1'b0, 4'd0, 32'h1100_0000);
    check("t1_iq_n", iq.size(), 32'd4);
    if (iq.size() == 4) begin
      check("t1_iq0", iq[0], 32'h1100_0000);
      check("t1_iq3", iq[3], 32'h1100_0003);
    end
    check("t1_dq_n", dq.size(), 32'd0);
    iq.delete(); dq.delete();

    // simultaneous: dcache wins first tie, icache afterwards
    i_araddr = 32'h2000_0080; i_arvalid = 1'b1;
    d_araddr = 32'h3000_0010; d_arvalid = 1'b1;
    do_ar(1'b1, 32'h3000_0010, 8'd3, 0);
    do_r(4, 3, -1, 1'b0, 4'd1, 32'hD200_0000);
    do_ar(1'b0, 32'h2000_0080, 8'd3, 1);
    do_r(4, 3, -1, 1'b0, 4'd0, 32'hA200_0000);
    check("t2_dq_n", dq.size(), 32'd4);
    check("t2_iq_n", iq.size(), 32'd4);
    iq.delete(); dq.delete();

    // dcache twice, icache waiting: d, i, d
    i_araddr = 32'h4000_0000; i_arvalid = 1'b1;
    d_araddr = 32'h5000_0020; d_arvalid = 1'b1;
    do_ar(1'b1, 32'h5000_0020, 8'd3, 0);
    d_araddr = 32'h5000_0040; d_arvalid = 1'b1;
    do_r(4, 3, -1, 1'b0, 4'd1, 32'hD300_0000);
    do_ar(1'b0, 32'h4000_0000, 8'd3, 0);
    do_r(4, 3, -1, 1'b0, 4'd0, 32'hA300_0000);
    do_ar(1'b1, 32'h5000_0040, 8'd3, 0);
    do_r(4, 3, -1, 1'b0, 4'd1, 32'hD310_0000);
    check("t3_dq_n", dq.size(), 32'd8);
    check("t3_iq_n", iq.size(), 32'd4);
    if (dq.size() == 8) check("t3_dq4", dq[4], 32'hD310_0000);
    iq.delete(); dq.delete();

    // uncached single beat
    d_uncached = 1'b1;
    d_araddr = 32'h6000_0004; d_arvalid = 1'b1;
    do_ar(1'b1, 32'h6000_0004, 8'd0, 0);
    d_uncached = 1'b0;
    do_r(1, 0, -1, 1'b0, 4'd1, 32'hD400_0000);
    check("t4_dq_n", dq.size(), 32'd1);
    check("t4_iq_n", iq.size(), 32'd0);
    iq.delete(); dq.delete();

    // icache backpressure
    i_araddr = 32'h7000_0000; i_arvalid = 1'b1;
    do_ar(1'b0, 32'h7000_0000, 8'd3, 0);
    do_r(4, 3, -1, 1'b1, 4'd0, 32'hA500_0000);
    check("t5_iq_n", iq.size(), 32'd4);
    if (iq.size() == 4) check("t5_iq2", iq[2], 32'hA500_0002);
    iq.delete(); dq.delete();

    // error response on beat 2, flag sticks across a clean burst
    i_araddr = 32'h7100_0000; i_arvalid = 1'b1;
    do_ar(1'b0, 32'h7100_0000, 8'd3, 0);
    do_r(4, 3, 1, 1'b0, 4'd0, 32'hA600_0000);
    check("t6_err_set", rd_err, 32'd1);
    d_uncached = 1'b1;
    d_araddr = 32'h6100_0000; d_arvalid = 1'b1;
    do_ar(1'b1, 32'h6100_0000, 8'd0, 0);
    d_uncached = 1'b0;
    do_r(1, 0, -1, 1'b0, 4'd1, 32'hD600_0000);
    check("t6_err_sticky", rd_err, 32'd1);
    rstn = 1'b0;
    tick();
    check("t6_err_clr", rd_err, 32'd0);
    rstn = 1'b1;
    tick();

    // early rlast on beat 3 of 4
    d_araddr = 32'h3100_0000; d_arvalid = 1'b1;
    do_ar(1'b1, 32'h3100_0000, 8'd3, 0);
    do_r(3, 2, -1, 1'b0, 4'd1, 32'hD700_0000);
    check("t6_early_rlast", rd_err, 32'd1);
    iq.delete(); dq.delete();

    // reset in the middle of a burst
    i_araddr = 32'h7200_0000; i_arvalid = 1'b1;
    do_ar(1'b0, 32'h7200_0000, 8'd3, 0);
    m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'hA800_0000;
    tick();
    check("t6_mid_rvalid", i_rvalid, 32'd1);
    rstn = 1'b0;
    #1;
    check("t6_rst_rvalid", i_rvalid, 32'd0);
    check("t6_rst_rready", m_rready, 32'd0);
    check("t6_rst_err", rd_err, 32'd0);
    tick();
    m_rvalid = 1'b0;
    rstn = 1'b1;
    tick();
    iq.delete(); dq.delete();

    // recovery after reset
    d_uncached = 1'b1;
    d_araddr = 32'h6200_0000; d_arvalid = 1'b1;
    do_ar(1'b1, 32'h6200_0000, 8'd0, 0);
    d_uncached = 1'b0;
    do_r(1, 0, -1, 1'b0, 4'd1, 32'hD900_0000);
    check("t7_dq_n", dq.size(), 32'd1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
